// File: rtl/copro_result_buffer.sv
// Result FIFO between the coprocessor ALU and the CV-X-IF result channel.
// Absorbs every ALU result and throttles issue so that no result is dropped.
module copro_result_buffer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4,
    parameter type hartid_t = logic,
    parameter type id_t     = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       alu_valid_i,
    input  logic [XLEN-1:0]            alu_result_i,
    input  hartid_t                    alu_hartid_i,
    input  id_t                        alu_id_i,
    input  logic [4:0]                 alu_rd_i,
    input  logic                       alu_we_i,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic [XLEN-1:0]            result_data_o,
    output hartid_t                    result_hartid_o,
    output id_t                        result_id_o,
    output logic [4:0]                 result_rd_o,
    output logic                       result_we_o,
    output logic                       issue_stall_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] data;
        hartid_t         hartid;
        id_t             id;
        logic [4:0]      rd;
        logic            we;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          wr_entry;
    entry_t          head;
    logic [PW-1:0]   rptr;
    logic [PW-1:0]   wptr;
    logic [CW-1:0]   count;
    logic            overflow;
    logic            full;
    logic            push;
    logic            pop;
    logic            drop;

    assign full = (count == CW'(DEPTH));
    assign pop  = result_valid_o && result_ready_i;
    // A full FIFO still accepts a result when the head leaves in the same cycle.
    assign push = alu_valid_i && (!full || pop);
    assign drop = alu_valid_i && full && !pop;

    assign wr_entry = '{
        data:   alu_result_i,
        hartid: alu_hartid_i,
        id:     alu_id_i,
        rd:     alu_rd_i,
        we:     alu_we_i
    };

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= wr_entry;
                wptr      <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign head = mem[rptr];

    assign result_valid_o  = (count != '0);
    assign result_data_o   = head.data;
    assign result_hartid_o = head.hartid;
    assign result_id_o     = head.id;
    assign result_rd_o     = head.rd;
    assign result_we_o     = head.we;

    // Occupancy plus the result already in flight inside the ALU.
    assign issue_stall_o = ({1'b0, count} + {{CW{1'b0}}, alu_valid_i})
                           >= (CW + 1)'(DEPTH);

    assign count_o    = count;
    assign overflow_o = overflow;

endmodule
